des_decrypt_core: RTL and testbench
===================================

Name: des_decrypt_core

Overview:
- Iterative 16-round DES decryption engine; one Feistel round per clock.
- Instantiates the team's existing combinational S-box modules sbox1..sbox8, one of each; all eight evaluate in parallel every round.
- Sits on the receive side of the cipher datapath: ciphertext block and 64-bit key in over a valid/ready handshake, plaintext block out over a valid/ready handshake.
- It is the inverse-direction counterpart of the encrypt path: same round function, subkeys applied K16..K1.

Parameters:
- PARITY_CHECK, default 0. When 1, each key byte is checked for odd parity and the result is reported on key_err. When 0, key_err is tied to 0.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: ciphertext and key are valid.
- in_ready, output, 1: core can accept a block.
- ciphertext, input, [64:1]: DES bit n maps to index 65-n, so [64] is DES bit 1.
- key, input, [64:1]: same bit mapping as ciphertext; parity bits are included.
- out_valid, output, 1: plaintext is valid.
- out_ready, input, 1: downstream accepts the plaintext.
- plaintext, output, [64:1]: decrypted block.
- key_err, output, 1: parity failure flag for the key of the current output block.
- busy, output, 1: high while in the ROUND or DONE state.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - State goes to IDLE.
  - in_ready=1; out_valid=0; busy=0; key_err=0.
  - plaintext=0, L/R/C/D registers=0, round counter=0.
  - Reset asserted mid-operation aborts the block; no output is produced for it.
- State machine: IDLE -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, register L0/R0 = IP(ciphertext) and C/D = PC1(key).
  - On the same edge set round=1, latch key parity into key_err (if PARITY_CHECK=1), and go to ROUND.
- ROUND (in_ready=0):
  - Decryption key schedule rotates C and D right (28-bit each) before PC2.
  - Rotation per round: round 1 = 0 bits; rounds 2, 9, 16 = 1 bit; all other rounds = 2 bits.
  - Rotated C/D are registered, subkey K = PC2(C,D), and the resulting key is K17-round.
  - Round function f = P(S1..S8(E(R) xor K)). S-box i receives the 6-bit slice [6:1], with [6] being the first DES bit of the slice.
  - Update per edge: L <= R, R <= L xor f, round <= round+1.
  - On the edge that completes round 16: go to DONE, register plaintext = FP({R16, L16}) (swap before FP), and set out_valid=1.
- Latency:
  - Accept edge = edge 0; rounds execute on edges 1..16.
  - out_valid is high after edge 16.
  - Minimum block period is 18 cycles (accept + 16 rounds + one output handshake cycle).
- DONE:
  - out_valid=1; plaintext and key_err stay stable until an edge with out_ready=1.
  - On that edge: out_valid <= 0 and go to IDLE.
  - in_ready rises only after returning to IDLE; there is no same-edge re-accept.
- Handshake and timing:
  - in_valid while busy is ignored; upstream holds its block.
  - out_ready while out_valid=0 has no effect.
  - Back-pressure of any length is legal.
- key_err is updated only at accept and is cleared by reset.
- Parity rule: a byte with an even number of ones counts as a parity error, and any failing byte sets key_err. Decryption proceeds regardless of key_err.
- All arithmetic is XOR and permutation only: no carries, and no widths beyond those stated.

Test Plan:
- Reset, then key=133457799BBCDFF1, ciphertext=85E813540F0AB405 -> out_valid high exactly 16 edges after accept; plaintext=0123456789ABCDEF; key_err=0.
- key=0E329232EA6D0D73, ciphertext=0000000000000000 -> plaintext=8787878787878787.
- PARITY_CHECK=1, key=0000000000000000, ciphertext=8CA64DE9C1B123A7 -> plaintext=0000000000000000; key_err=1.
- Hold out_ready=0 for 20 cycles after out_valid, while in_valid=1 with a second block:
  - plaintext stays stable and in_ready stays 0 throughout.
  - Release out_ready -> next cycle in_ready=1; second block accepted and decrypted correctly.
- Assert rst_n=0 for one edge at round 8 -> next cycle in_ready=1, out_valid=0, plaintext=0; a fresh block then decrypts correctly.
- Back-to-back blocks with out_ready tied 1 -> one result every 18 cycles, each matching a software DES model over 1000 random key/ciphertext pairs.

Source files
------------

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys K16..K1.
// Contains the eight combinational S-box lookups used by the round function.

module sbox1 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    // Row is the outer bit pair, column the inner four bits.
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module sbox2 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module sbox3 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module sbox4 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module sbox5 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module sbox6 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module sbox7 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module sbox8 (input logic [6:1] b, output logic [4:1] s);
    localparam logic [255:0] TBL =
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    logic [5:0] idx;
    assign idx = {b[6], b[1], b[5:2]};
    assign s   = TBL[4*(63-idx) +: 4];
endmodule

module des_decrypt_core #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] ciphertext,
    input  logic [64:1] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] plaintext,
    output logic        key_err,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Tables list the source DES bit for each output DES bit (1-based).
    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [64:1] ip(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 1; i <= 64; i++) y[65-i] = x[65-IP_T[i-1]];
        return y;
    endfunction

    function automatic logic [64:1] fp(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 1; i <= 64; i++) y[65-i] = x[65-FP_T[i-1]];
        return y;
    endfunction

    function automatic logic [48:1] e_exp(input logic [32:1] x);
        logic [48:1] y;
        for (int i = 1; i <= 48; i++) y[49-i] = x[33-E_T[i-1]];
        return y;
    endfunction

    function automatic logic [32:1] p_perm(input logic [32:1] x);
        logic [32:1] y;
        for (int i = 1; i <= 32; i++) y[33-i] = x[33-P_T[i-1]];
        return y;
    endfunction

    function automatic logic [56:1] pc1(input logic [64:1] x);
        logic [56:1] y;
        for (int i = 1; i <= 56; i++) y[57-i] = x[65-PC1_T[i-1]];
        return y;
    endfunction

    function automatic logic [48:1] pc2(input logic [56:1] x);
        logic [48:1] y;
        for (int i = 1; i <= 48; i++) y[49-i] = x[57-PC2_T[i-1]];
        return y;
    endfunction

    // A key byte with an even number of ones fails odd parity.
    function automatic logic parity_err(input logic [64:1] k);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 8; i++) err = err | ~(^k[8*i+1 +: 8]);
        return err;
    endfunction

    logic [1:0]  state;
    logic [4:0]  round;
    logic [32:1] l, r;
    logic [28:1] c, d;
    logic [28:1] c_rot, d_rot;
    logic [48:1] subkey, sin;
    logic [32:1] sout, f, r_next;
    logic [64:1] ip_in;
    logic [56:1] pc1_key;

    // Decryption walks the schedule backwards, so C/D rotate right; round 1 uses C0/D0 as-is.
    always_comb begin
        c_rot = c;
        d_rot = d;
        case (round)
            5'd1:                c_rot = c;
            5'd2, 5'd9, 5'd16: begin
                c_rot = {c[1], c[28:2]};
                d_rot = {d[1], d[28:2]};
            end
            default: begin
                c_rot = {c[2:1], c[28:3]};
                d_rot = {d[2:1], d[28:3]};
            end
        endcase
    end

    assign subkey  = pc2({c_rot, d_rot});
    assign sin     = e_exp(r) ^ subkey;
    assign ip_in   = ip(ciphertext);
    assign pc1_key = pc1(key);

    sbox1 u_sbox1 (.b(sin[48:43]), .s(sout[32:29]));
    sbox2 u_sbox2 (.b(sin[42:37]), .s(sout[28:25]));
    sbox3 u_sbox3 (.b(sin[36:31]), .s(sout[24:21]));
    sbox4 u_sbox4 (.b(sin[30:25]), .s(sout[20:17]));
    sbox5 u_sbox5 (.b(sin[24:19]), .s(sout[16:13]));
    sbox6 u_sbox6 (.b(sin[18:13]), .s(sout[12:9]));
    sbox7 u_sbox7 (.b(sin[12:7]),  .s(sout[8:5]));
    sbox8 u_sbox8 (.b(sin[6:1]),   .s(sout[4:1]));

    assign f      = p_perm(sout);
    assign r_next = l ^ f;

    assign in_ready = (state == IDLE);
    assign busy     = (state == ROUND) || (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            round     <= 5'd0;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            plaintext <= '0;
            out_valid <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l       <= ip_in[64:33];
                        r       <= ip_in[32:1];
                        c       <= pc1_key[56:29];
                        d       <= pc1_key[28:1];
                        round   <= 5'd1;
                        key_err <= PARITY_CHECK && parity_err(key);
                        state   <= ROUND;
                    end
                end
                ROUND: begin
                    l     <= r;
                    r     <= r_next;
                    c     <= c_rot;
                    d     <= d_rot;
                    round <= round + 5'd1;
                    if (round == 5'd16) begin
                        // Final swap: preoutput is R16 followed by L16.
                        plaintext <= fp({r_next, r});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: known-answer vectors, back-pressure,
// mid-block reset and 1000 back-to-back random blocks against a software DES model.

module tb_des_decrypt_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [64:1] ciphertext = '0;
    logic [64:1] key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [64:1] plaintext;
    logic        key_err;
    logic        busy;

    always #5 clk = ~clk;

    des_decrypt_core #(.PARITY_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ciphertext(ciphertext), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .plaintext(plaintext), .key_err(key_err), .busy(busy)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- software DES model ----------------
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Values are held in the low bits; DES bit n of a w-bit value sits at index w-n.
    function automatic logic [63:0] perm(input logic [63:0] x, input int iw, input int ow, input int tid);
        logic [63:0] y;
        int t;
        y = '0;
        t = 1;
        for (int i = 1; i <= ow; i++) begin
            case (tid)
                0: t = IP_T[i-1];
                1: t = FP_T[i-1];
                2: t = E_T[i-1];
                3: t = P_T[i-1];
                4: t = PC1_T[i-1];
                default: t = PC2_T[i-1];
            endcase
            y[ow-i] = x[iw-t];
        end
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        int          idx;
        logic [255:0] tbl;
        x = perm({32'b0, rr}, 32, 48, 2) ^ {16'b0, k};
        s = '0;
        for (int j = 0; j < 8; j++) begin
            six = x[47-6*j -: 6];
            idx = {six[5], six[0]} * 16 + six[4:1];
            tbl = SB[j] >> (4 * (63 - idx));
            s[31-4*j -: 4] = tbl[3:0];
        end
        return perm({32'b0, s}, 32, 32, 3);
    endfunction

    function automatic logic [63:0] des_dec(input logic [63:0] k, input logic [63:0] ct);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] lr;
        logic [31:0] l, r, tmp;
        int sh;
        cd = perm(k, 64, 56, 4);
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
            c = (c << sh) | (c >> (28 - sh));
            d = (d << sh) | (d >> (28 - sh));
            ks[i] = perm({8'b0, c, d}, 56, 48, 5);
        end
        lr = perm(ct, 64, 64, 0);
        l = lr[63:32];
        r = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r = l ^ feistel(r, ks[15-i]);
            l = tmp;
        end
        return perm({r, l}, 64, 64, 1);
    endfunction

    function automatic logic parity_model(input logic [63:0] k);
        logic e;
        e = 1'b0;
        for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) e = 1'b1;
        return e;
    endfunction

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        logic [63:0] pt;
        logic        ke;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   last_acc = -1;
    bit   b2b = 1'b0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            last_acc = -1;
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e.pt  = des_dec(key, ciphertext);
                e.ke  = parity_model(key);
                e.acc = cyc + 1;
                sb_q.push_back(e);
                if (b2b && last_acc >= 0) check("period", cyc + 1 - last_acc, 18);
                last_acc = cyc + 1;
            end
            if (out_valid && !ov_prev && sb_q.size() > 0)
                check("latency", cyc - sb_q[0].acc, 16);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_plaintext", plaintext, e.pt);
                    check("sb_key_err", key_err, e.ke);
                end
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [63:0] k, input logic [63:0] ct);
        key = k;
        ciphertext = ct;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        check(tag, 0, 1);
    endtask

    task automatic kat(input string tag, input logic [63:0] k, input logic [63:0] ct,
                       input logic [63:0] pt, input logic ke);
        send(k, ct);
        @(negedge clk);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        wait_out({tag, "_timeout"});
        check({tag, "_pt"}, plaintext, pt);
        check({tag, "_key_err"}, key_err, ke);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] ka, ca, kb, cb;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_key_err", key_err, 0);
        check("rst_plaintext", plaintext, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        kat("kat1", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b0);
        kat("kat2", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 1'b0);
        kat("kat3", 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000, 1'b1);

        // Back-pressure: block A waits in DONE while block B is offered.
        ka = {$urandom, $urandom};
        ca = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        cb = {$urandom, $urandom};
        out_ready = 1'b0;
        send(ka, ca);
        key = kb;
        ciphertext = cb;
        in_valid = 1'b1;
        wait_out("bp_timeout");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_pt", plaintext, des_dec(ka, ca));
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out("bp_b_timeout");
        check("bp_b_pt", plaintext, des_dec(kb, cb));
        @(posedge clk);
        #1;

        // Reset on the edge that would execute round 8.
        send({$urandom, $urandom}, {$urandom, $urandom});
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_plaintext", plaintext, 0);
        check("midrst_busy", busy, 0);
        check("midrst_key_err", key_err, 0);
        @(posedge clk);
        #1;
        kat("post_rst", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b0);

        // Back-to-back random blocks.
        b2b = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 1000; i++) send({$urandom, $urandom}, {$urandom, $urandom});
        for (int n = 0; n < 100 && sb_q.size() > 0; n++) @(negedge clk);
        check("drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
